// File: rtl/approx_add_arbiter.sv
// Two-requester round-robin front end sharing one configurable-approximation
// ripple-carry adder, with valid/ready handshakes and a completed-response counter.
module approx_add_arbiter #(
    parameter int W          = 8,
    parameter int APPROX_RST = 6,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W:0]       rsp_sum,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_approx_bits,
    output logic [3:0]       approx_bits_q,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]       W4      = 4'(W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t         state;
    state_t         state_nxt;
    logic           owner;
    logic           last_served;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           rsp_handshake;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W:0]     sum_comb;
    logic [3:0]     cfg_sat;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_served;
                grant1 = ~last_served;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready    = grant0 & ~cfg_we;
    assign req1_ready    = grant1 & ~cfg_we;
    assign accept        = req0_ready | req1_ready;
    assign rsp0_valid    = (state == RESP) & ~owner;
    assign rsp1_valid    = (state == RESP) & owner;
    assign rsp_handshake = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);
    assign cfg_sat       = (cfg_approx_bits > W4) ? W4 : cfg_approx_bits;

    // Low k bits use the approximate cell whose carry-out is simply X_i.
    always_comb begin
        logic [W:0] carry;
        carry    = '0;
        sum_comb = '0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(approx_bits_q)) begin
                sum_comb[i] = b_q[i] & (~a_q[i] | carry[i]);
                carry[i+1]  = a_q[i];
            end else begin
                sum_comb[i] = a_q[i] ^ b_q[i] ^ carry[i];
                carry[i+1]  = (a_q[i] & b_q[i]) | (a_q[i] & carry[i]) | (b_q[i] & carry[i]);
            end
        end
        sum_comb[W] = carry[W];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Last-served starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            owner         <= 1'b0;
            last_served   <= 1'b1;
            rsp_sum       <= '0;
            approx_bits_q <= 4'(APPROX_RST);
            txn_count     <= '0;
        end else begin
            if (accept) begin
                a_q         <= req1_ready ? req1_a : req0_a;
                b_q         <= req1_ready ? req1_b : req0_b;
                owner       <= req1_ready;
                last_served <= req1_ready;
            end
            if (state == EXEC) begin
                rsp_sum <= sum_comb;
            end
            if ((state == IDLE) && cfg_we) begin
                approx_bits_q <= cfg_sat;
            end
            if (rsp_handshake) begin
                txn_count <= txn_count + CNT_ONE;
            end
        end
    end

endmodule
